viterbi_err_sched: RTL and testbench

- Error-injection scheduler for the Viterbi tx/rx channel.
- Sits between the encoder2 output and the decoder input, and decides on which symbols to corrupt using an LFSR-driven trigger.
- Shapes corruption into bursts separated by a guard gap, confined to a measurement window.
- Reports injected symbol and bit counts so the bench can relate them to decoder bit errors.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/viterbi_err_sched_if.sv | 29 ++
 rtl/viterbi_lfsr16.sv | 30 +++
 rtl/viterbi_err_sched.sv | 138 +++++++++++++
 tb/tb_viterbi_err_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi channel error-injection scheduler.
package viterbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_BURST = 3'd2,
        ST_GUARD = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_RESET = 16'h0001;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage

// File: rtl/viterbi_err_sched_if.sv
// Symbol stream, control and status bundle between the channel bench and the scheduler.
interface viterbi_err_sched_if #(
    parameter int CW = 16
);
    logic          enable_i;
    logic          seed_load_i;
    logic [15:0]   seed_i;
    logic [3:0]    burst_len_i;
    logic [1:0]    err_pattern_i;
    logic          sym_valid_i;
    logic [1:0]    sym_i;
    logic          sym_valid_o;
    logic [1:0]    sym_o;
    logic          inj_active_o;
    logic [CW-1:0] word_ct_o;
    logic [CW-1:0] err_sym_ct_o;
    logic [CW-1:0] err_bit_ct_o;
    logic          done_o;

    modport master (
        output enable_i, seed_load_i, seed_i, burst_len_i, err_pattern_i, sym_valid_i, sym_i,
        input  sym_valid_o, sym_o, inj_active_o, word_ct_o, err_sym_ct_o, err_bit_ct_o, done_o
    );

    modport slave (
        input  enable_i, seed_load_i, seed_i, burst_len_i, err_pattern_i, sym_valid_i, sym_i,
        output sym_valid_o, sym_o, inj_active_o, word_ct_o, err_sym_ct_o, err_bit_ct_o, done_o
    );
endinterface

// File: rtl/viterbi_lfsr16.sv
// 16-bit Fibonacci LFSR with load and step enable; a zero seed is replaced by the reset value.
module viterbi_lfsr16
    import viterbi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_r;

    // Shift register: load has priority over step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LFSR_RESET;
        end else if (load) begin
            state_r <= (seed == 16'h0000) ? LFSR_RESET : seed;
        end else if (step) begin
            state_r <= {state_r[14:0], ^(state_r & LFSR_TAPS)};
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/viterbi_err_sched.sv
// Error-injection scheduler: LFSR-triggered corruption bursts with guard gaps inside a
// measurement window, plus injected symbol/bit counters.
module viterbi_err_sched
    import viterbi_pkg::*;
#(
    parameter int N      = 5,
    parameter int WINDOW = 256,
    parameter int GUARD  = 8,
    parameter int CW     = 16
) (
    input logic                clk,
    input logic                rst,
    viterbi_err_sched_if.slave bus
);

    localparam logic [15:0] TRIG_MASK = 16'((32'd1 << N) - 32'd1);

    sched_state_t  state_r;
    logic [15:0]   phase_r;
    logic [CW-1:0] word_ct_r;
    logic [CW-1:0] err_sym_ct_r;
    logic [CW-1:0] err_bit_ct_r;
    logic          done_r;
    logic          sym_valid_r;
    logic [1:0]    sym_r;
    logic          inj_r;

    logic [15:0]   lfsr_s;
    logic          accept_s;
    logic          load_s;
    logic          corrupt_s;
    logic [1:0]    mask_s;
    logic          trig_s;
    logic          win_end_s;
    logic [15:0]   burst_len_s;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
        logic [CW:0] sum;
        sum = {1'b0, a} + {{(CW-1){1'b0}}, b};
        return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
    endfunction

    viterbi_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (accept_s),
        .load  (load_s),
        .seed  (bus.seed_i),
        .state (lfsr_s)
    );

    // Per-symbol decode of the current state and LFSR trigger
    always_comb begin
        accept_s    = bus.sym_valid_i && (state_r != ST_IDLE);
        load_s      = bus.seed_load_i && (state_r == ST_IDLE);
        corrupt_s   = bus.sym_valid_i && (state_r == ST_BURST);
        mask_s      = corrupt_s ? bus.err_pattern_i : 2'b00;
        trig_s      = &(lfsr_s | ~TRIG_MASK);
        win_end_s   = (word_ct_r == CW'(WINDOW - 1));
        burst_len_s = (bus.burst_len_i == 4'd0) ? 16'd1 : {12'd0, bus.burst_len_i};
    end

    // Scheduler FSM with registered datapath and counters; enable low overrides to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            phase_r      <= 16'd0;
            word_ct_r    <= '0;
            err_sym_ct_r <= '0;
            err_bit_ct_r <= '0;
            done_r       <= 1'b0;
            sym_valid_r  <= 1'b0;
            sym_r        <= 2'b00;
            inj_r        <= 1'b0;
        end else begin
            sym_valid_r <= bus.sym_valid_i;
            inj_r       <= corrupt_s;
            if (bus.sym_valid_i) begin
                sym_r <= bus.sym_i ^ mask_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable_i) begin
                        state_r      <= ST_ARMED;
                        word_ct_r    <= '0;
                        err_sym_ct_r <= '0;
                        err_bit_ct_r <= '0;
                        done_r       <= 1'b0;
                    end
                end
                ST_ARMED, ST_BURST, ST_GUARD: begin
                    if (accept_s) begin
                        word_ct_r <= sat_add(word_ct_r, 2'd1);
                        if (corrupt_s) begin
                            err_sym_ct_r <= sat_add(err_sym_ct_r, 2'd1);
                            err_bit_ct_r <= sat_add(err_bit_ct_r, popcount2(bus.err_pattern_i));
                        end
                        // Window end wins over any burst/guard progress
                        if (win_end_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (state_r == ST_ARMED) begin
                            if (trig_s) begin
                                state_r <= ST_BURST;
                                phase_r <= burst_len_s;
                            end
                        end else if (phase_r != 16'd1) begin
                            phase_r <= phase_r - 16'd1;
                        end else if ((state_r == ST_BURST) && (GUARD != 0)) begin
                            state_r <= ST_GUARD;
                            phase_r <= 16'(GUARD);
                        end else begin
                            state_r <= ST_ARMED;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (!bus.enable_i) begin
                state_r <= ST_IDLE;
            end
        end
    end

    assign bus.sym_valid_o  = sym_valid_r;
    assign bus.sym_o        = sym_r;
    assign bus.inj_active_o = inj_r;
    assign bus.word_ct_o    = word_ct_r;
    assign bus.err_sym_ct_o = err_sym_ct_r;
    assign bus.err_bit_ct_o = err_bit_ct_r;
    assign bus.done_o       = done_r;

endmodule

// File: tb/tb_viterbi_err_sched.sv
// Scoreboard bench for viterbi_err_sched: directed scenarios plus randomized traffic
// checked against a per-symbol behavioural model of the scheduling rules.
module tb_viterbi_err_sched;

    localparam int N      = 5;
    localparam int WINDOW = 256;
    localparam int GUARD  = 8;
    localparam int CW     = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_BURST = 2;
    localparam int M_GUARD = 3;
    localparam int M_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_rst;
    logic [15:0] gen_state;

    always #5 clk = ~clk;

    viterbi_err_sched_if #(.CW(CW)) bus ();

    viterbi_err_sched #(.N(N), .WINDOW(WINDOW), .GUARD(GUARD), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Symbol data generator
    viterbi_lfsr16 u_gen (
        .clk   (clk),
        .rst   (gen_rst),
        .step  (1'b1),
        .load  (1'b0),
        .seed  (16'h0000),
        .state (gen_state)
    );

    typedef struct {
        bit       v;
        bit [1:0] sym;
        bit       inj;
        int       word;
        int       esym;
        int       ebit;
        bit       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    int       m_st;
    int       m_left;
    int       m_lfsr;
    int       m_word;
    int       m_esym;
    int       m_ebit;
    bit       m_done;
    bit [1:0] m_sym;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 32'hFFFF;
    endfunction

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_left = 0; m_lfsr = 1;
        m_word = 0; m_esym = 0; m_ebit = 0; m_done = 1'b0; m_sym = 2'b00;
    endtask

    // Drive one cycle of inputs and queue what the outputs must look like after the clock
    task automatic apply(input bit en, input bit sl, input bit [15:0] sd,
                         input bit [3:0] bl, input bit [1:0] pat, input bit v);
        bit [1:0] s;
        bit       corrupt;
        bit       trig;
        exp_t     e;
        s = gen_state[1:0] ^ 2'($urandom_range(0, 3));
        bus.enable_i = en; bus.seed_load_i = sl; bus.seed_i = sd;
        bus.burst_len_i = bl; bus.err_pattern_i = pat;
        bus.sym_valid_i = v; bus.sym_i = s;
        corrupt = v && (m_st == M_BURST);
        if (v) m_sym = s ^ (corrupt ? pat : 2'b00);
        if (m_st == M_IDLE) begin
            if (sl) m_lfsr = (sd == 16'h0000) ? 1 : int'(sd);
            if (en) begin
                m_st = M_ARMED; m_word = 0; m_esym = 0; m_ebit = 0; m_done = 1'b0;
            end
        end else if (v) begin
            trig   = (m_lfsr % (1 << N)) == ((1 << N) - 1);
            m_lfsr = lfsr_next(m_lfsr);
            if (m_st != M_DONE) begin
                m_word = sat(m_word + 1);
                if (corrupt) begin
                    m_esym = sat(m_esym + 1);
                    m_ebit = sat(m_ebit + $countones(pat));
                end
                if (m_word == WINDOW) begin
                    m_st = M_DONE; m_done = 1'b1;
                end else if (m_st == M_ARMED) begin
                    if (trig) begin m_st = M_BURST; m_left = (bl == 4'd0) ? 1 : int'(bl); end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_st == M_BURST && GUARD > 0) begin m_st = M_GUARD; m_left = GUARD; end
                        else m_st = M_ARMED;
                    end
                end
            end
        end
        if (!en) m_st = M_IDLE;
        e.v = v; e.sym = m_sym; e.inj = corrupt; e.word = m_word;
        e.esym = m_esym; e.ebit = m_ebit; e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit en, input bit sl, input bit [15:0] sd,
                         input bit [3:0] bl, input bit [1:0] pat, input bit v);
        @(negedge clk);
        apply(en, sl, sd, bl, pat, v);
    endtask

    task automatic wait_out();
        @(posedge clk);
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.sym_valid_o), 32'd0);
        check({tag, "_sym"},   32'(bus.sym_o), 32'd0);
        check({tag, "_inj"},   32'(bus.inj_active_o), 32'd0);
        check({tag, "_word"},  32'(bus.word_ct_o), 32'd0);
        check({tag, "_esym"},  32'(bus.err_sym_ct_o), 32'd0);
        check({tag, "_ebit"},  32'(bus.err_bit_ct_o), 32'd0);
        check({tag, "_done"},  32'(bus.done_o), 32'd0);
    endtask

    // Monitor: compares each queued expectation shortly after the clock edge that produced it
    always begin
        @(posedge clk);
        #2;
        if (rst === 1'b1 && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sym_valid_o",  32'(bus.sym_valid_o),  32'(mon_e.v));
            check("sym_o",        32'(bus.sym_o),        32'(mon_e.sym));
            check("inj_active_o", 32'(bus.inj_active_o), 32'(mon_e.inj));
            check("word_ct_o",    32'(bus.word_ct_o),    32'(mon_e.word));
            check("err_sym_ct_o", 32'(bus.err_sym_ct_o), 32'(mon_e.esym));
            check("err_bit_ct_o", 32'(bus.err_bit_ct_o), 32'(mon_e.ebit));
            check("done_o",       32'(bus.done_o),       32'(mon_e.done));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; gen_rst = 1'b0;
        bus.enable_i = 1'b0; bus.seed_load_i = 1'b0; bus.seed_i = 16'h0000;
        bus.burst_len_i = 4'd0; bus.err_pattern_i = 2'b00;
        bus.sym_valid_i = 1'b0; bus.sym_i = 2'b00;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk); #2;
        rst = 1'b1; gen_rst = 1'b1;
        apply(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);

        // Full window with seed ACE1, 4-symbol bursts of pattern 10
        drive(1'b1, 1'b1, 16'hACE1, 4'd4, 2'b10, 1'b1);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 16'h0, 4'd4, 2'b10, 1'b1);
        wait_out();
        check("A_done", 32'(bus.done_o), 32'd1);
        check("A_word", 32'(bus.word_ct_o), 32'(WINDOW));
        check("A_esym", 32'(bus.err_sym_ct_o), 32'(m_esym));
        check("A_ebit_eq_esym", 32'(bus.err_bit_ct_o), 32'(m_esym));
        drive(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);

        // Forced trigger on the second symbol, burst length 0 acts as 1
        drive(1'b1, 1'b1, 16'h800F, 4'd0, 2'b10, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0, 4'd0, 2'b10, 1'b1);
        wait_out();
        check("B_esym_one", 32'(bus.err_sym_ct_o), 32'd1);
        drive(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);

        // Gapped input across a 3-symbol burst
        drive(1'b1, 1'b1, 16'h800F, 4'd3, 2'b01, 1'b0);
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, 16'h0, 4'd3, 2'b01, (i % 2) == 0);
        wait_out();
        check("C_esym", 32'(bus.err_sym_ct_o), 32'd3);
        drive(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);

        // Enable dropped after two of four burst symbols
        drive(1'b1, 1'b1, 16'h800F, 4'd4, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0, 4'd4, 2'b01, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 4'd4, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 4'd4, 2'b01, 1'b1);
        wait_out();
        check("D_esym_held", 32'(bus.err_sym_ct_o), 32'd2);
        drive(1'b1, 1'b1, 16'h800F, 4'd4, 2'b11, 1'b0);
        wait_out();
        check("D_esym_cleared", 32'(bus.err_sym_ct_o), 32'd0);

        // Pattern 11 over a 4-symbol burst
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0, 4'd4, 2'b11, 1'b1);
        wait_out();
        check("E_ebit", 32'(bus.err_bit_ct_o), 32'd8);
        check("E_esym", 32'(bus.err_sym_ct_o), 32'd4);
        drive(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a burst
        drive(1'b1, 1'b1, 16'h800F, 4'd8, 2'b10, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0, 4'd8, 2'b10, 1'b1);
        wait_out();
        check("F_pre_inj", 32'(bus.inj_active_o), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        model_reset();
        bus.enable_i = 1'b0; bus.sym_valid_i = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        apply(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 4'd8, 2'b10, 1'b1);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 16'h0, 4'd8, 2'b10, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit [15:0] sd;
            sd = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, sd,
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
        end

        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
